div_clock_selector: RTL and testbench
=====================================

Name: div_clock_selector

Overview:
- Downstream consumer of the eight-tap clock divider bank.
- Takes the divided square-wave taps, all registered in the `clk` domain, and selects one under software control.
- Switches between taps glitch-free, with no runt high or low pulse on the output.
- Emits a one-cycle `tick` enable on each selected rising edge and keeps a wrapping tick count for blink/timer logic.

Parameters:
- NTAPS, 8, number of divider taps; tap i toggles with period 2^(i+1) clk cycles.
- SELW, 3, width of the select field; requires NTAPS <= 2^SELW.
- CNTW, 16, width of `tick_count`.
- DEFAULT_SEL, 0, tap selected out of reset.

Ports:
- clk  in  1  system clock; same clock that drives the divider bank.
- rst  in  1  asynchronous, active-high reset.
- taps  in  NTAPS  divider outputs; bit i is the divide-by-2^(i+1) tap, synchronous to clk.
- tap_sel  in  SELW  requested tap index.
- cnt_clr  in  1  synchronous clear of `tick_count`.
- clk_out  out  1  registered, glitch-free selected clock.
- tick  out  1  one-cycle pulse on each 0->1 transition of `clk_out`.
- tick_count  out  CNTW  count of ticks, wraps.
- busy  out  1  high while a switch is in progress.
- sel_active  out  SELW  tap currently driving `clk_out`.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, and is named `rst`.
- Reset values:
  - state = RUN, sel_active = DEFAULT_SEL.
  - clk_out = 0, tick = 0, tick_count = 0, busy = 0.
  - internal pending = DEFAULT_SEL, clk_out_d = 0.
- Latency: in RUN, clk_out <= taps[sel_active] each cycle (1-cycle latency from taps).
- tick:
  - tick <= clk_out_next & ~clk_out, i.e. asserted in the same cycle clk_out first reads 1.
  - Exactly one tick per output high phase.
- FSM states:
  - RUN: clk_out follows the active tap. If tap_sel != sel_active and tap_sel < NTAPS, latch pending <= tap_sel, set busy = 1, go to DRAIN. If tap_sel >= NTAPS, the request is ignored and the FSM stays in RUN.
  - DRAIN: clk_out keeps following taps[sel_active] until a cycle where taps[sel_active] == 0. In that cycle clk_out <= 0 and the FSM goes to ARM. An in-progress high phase is never truncated.
  - ARM: clk_out held 0. On the first cycle where taps[pending] == 0: sel_active <= pending, busy <= 0, go to RUN. Entering RUN while the new tap is low guarantees its next high phase is full length.
- Requests during a switch: tap_sel changes while busy are ignored. tap_sel is re-evaluated in the first RUN cycle, so the final value wins after at most two switches.
- Output low time during a switch: at least 1 cycle. Output high time is always a full tap high phase.
- tick_count arithmetic:
  - Increments by 1 on tick, modulo 2^CNTW: 2^CNTW-1 -> 0, no saturation, no flag.
  - cnt_clr and tick in the same cycle: clear wins, tick_count = 0.
- Reset asserted mid-switch: immediate return to the reset values. Any pending selection is discarded.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset release, DEFAULT_SEL=0, taps driven by divider model:
  - clk_out alternates every cycle; tick every 2 cycles.
  - tick_count = 50 after 100 cycles; busy = 0.
- tap_sel 0 -> 3 (divide-by-16) while tap 0 is high:
  - busy rises the next cycle.
  - clk_out finishes its high phase, then stays low until tap 3 is low.
  - sel_active = 3; subsequent period is 16 cycles with 8 high / 8 low.
  - No high pulse shorter than 8 cycles is ever seen.
- tap_sel 3 -> 7 -> 1 changed mid-switch:
  - The 7 request completes first (high phase 128 cycles).
  - A second switch then lands on 1; busy pulses twice.
- tap_sel = 2 with NTAPS=2 build: request ignored, busy stays 0, sel_active unchanged.
- Preload tick_count to 0xFFFE via ticks, then two more ticks: count reads 0xFFFF then 0x0000. cnt_clr coincident with a tick gives 0.
- Assert rst during DRAIN with sel_active = 5: outputs return to reset values asynchronously. After release, sel_active = DEFAULT_SEL and busy = 0.

Source files
------------

// File: rtl/div_clock_selector.sv
// Glitch-free selector over the divider bank taps.
// Emits a tick on each selected rising edge and counts the ticks.
module div_clock_selector #(
  parameter int NTAPS       = 8,
  parameter int SELW        = 3,
  parameter int CNTW        = 16,
  parameter int DEFAULT_SEL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NTAPS-1:0] taps,
  input  logic [SELW-1:0] tap_sel,
  input  logic            cnt_clr,
  output logic            clk_out,
  output logic            tick,
  output logic [CNTW-1:0] tick_count,
  output logic            busy,
  output logic [SELW-1:0] sel_active
);

  localparam int TW = 2 ** SELW;
  localparam logic [SELW-1:0] DSEL = SELW'(DEFAULT_SEL);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] ARM   = 2'd2;

  logic [1:0]      state;
  logic [SELW-1:0] pending;
  logic [TW-1:0]   tapx;
  logic            req_ok;
  logic            cur_tap;
  logic            pnd_tap;
  logic            clk_nx;

  assign tapx    = TW'(taps);
  assign cur_tap = tapx[sel_active];
  assign pnd_tap = tapx[pending];

  generate
    if (NTAPS >= TW) begin : g_full
      assign req_ok = 1'b1;
    end else begin : g_part
      assign req_ok = {1'b0, tap_sel} < (SELW + 1)'(NTAPS);
    end
  endgenerate

  // DRAIN keeps following the old tap so its high phase is never cut.
  assign clk_nx = (state != ARM) & cur_tap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      sel_active <= DSEL;
      pending    <= DSEL;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
      busy       <= 1'b0;
    end else begin
      clk_out <= clk_nx;
      tick    <= clk_nx & ~clk_out;
      if (cnt_clr)
        tick_count <= '0;
      else if (tick)
        tick_count <= tick_count + CNTW'(1);
      unique case (state)
        RUN: begin
          if (req_ok && tap_sel != sel_active) begin
            pending <= tap_sel;
            busy    <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (!cur_tap)
            state <= ARM;
        end
        ARM: begin
          if (!pnd_tap) begin
            sel_active <= pending;
            busy       <= 1'b0;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_div_clock_selector.sv
// Directed bench for div_clock_selector.
// Table vectors plus divider-driven switch sequences.
module tb_div_clock_selector;

  logic        clk;
  logic        rst;
  logic        use_div;
  logic [15:0] dcnt;
  logic [7:0]  vtaps;
  logic [7:0]  taps8;
  logic [2:0]  sel8;
  logic        clr8;
  logic        co8, tick8, busy8;
  logic [15:0] cnt8;
  logic [2:0]  sa8;
  logic [1:0]  taps2;
  logic [2:0]  sel2;
  logic        clr2;
  logic        co2, tick2, busy2;
  logic [3:0]  cnt2;
  logic [2:0]  sa2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  taps;
    logic [2:0]  sel;
    logic        clr;
    logic        co;
    logic        tk;
    logic        by;
    logic [2:0]  sa;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];

  div_clock_selector u8 (
    .clk(clk), .rst(rst), .taps(taps8), .tap_sel(sel8),
    .cnt_clr(clr8), .clk_out(co8), .tick(tick8),
    .tick_count(cnt8), .busy(busy8), .sel_active(sa8)
  );

  div_clock_selector #(.NTAPS(2), .SELW(3), .CNTW(4)) u2 (
    .clk(clk), .rst(rst), .taps(taps2), .tap_sel(sel2),
    .cnt_clr(clr2), .clk_out(co2), .tick(tick2),
    .tick_count(cnt2), .busy(busy2), .sel_active(sa2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) dcnt <= '0;
    else     dcnt <= dcnt + 16'd1;

  assign taps8 = use_div ? dcnt[7:0] : vtaps;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_busy(input logic v, input int budget,
                           input string nm);
    int n = 0;
    while (busy8 !== v && n < budget) begin
      step();
      n++;
    end
    chk(nm, busy8, v);
  endtask

  task automatic measure(input string nm, input int hexp,
                         input int lexp);
    int  n = 0;
    int  hi = 0;
    int  lo = 0;
    logic prev = co8;
    bit  ok = 0;
    while (!ok && n < 600) begin
      step();
      n++;
      if (!prev && co8) ok = 1;
      prev = co8;
    end
    chk({nm, "_rise"}, ok, 1);
    while (ok && co8 && hi < 600) begin
      hi++;
      step();
    end
    while (ok && !co8 && lo < 600) begin
      lo++;
      step();
    end
    chk({nm, "_high"}, hi, hexp);
    chk({nm, "_low"}, lo, lexp);
  endtask

  task automatic pulse2(input logic clr_fall);
    taps2 = 2'b01;
    step();
    taps2 = 2'b00;
    clr2  = clr_fall;
    step();
    clr2  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; use_div = 1'b0; vtaps = '0;
    sel8 = '0; clr8 = 1'b0;
    taps2 = '0; sel2 = 3'd2; clr2 = 1'b0;

    tv.push_back('{8'h01, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0});
    tv.push_back('{8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1});
    tv.push_back('{8'h01, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'd1});
    tv.push_back('{8'h01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd2});
    tv.push_back('{8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0});
    tv.push_back('{8'h01, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0});
    tv.push_back('{8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0});
    tv.push_back('{8'h08, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0});
    tv.push_back('{8'h01, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 16'd0});
    tv.push_back('{8'h09, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd1});
    tv.push_back('{8'h08, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd1});
    tv.push_back('{8'h09, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd1});
    tv.push_back('{8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd1});
    tv.push_back('{8'h08, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'd1});
    tv.push_back('{8'h08, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 16'd2});
    tv.push_back('{8'h20, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'd2});
    tv.push_back('{8'h20, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'd2});
    tv.push_back('{8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'd2});
    tv.push_back('{8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'd2});
    tv.push_back('{8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'd2});
    tv.push_back('{8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'd2});
    tv.push_back('{8'hFF, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'd2});

    repeat (3) step();
    chk("rst_clk_out", co8, 0);
    chk("rst_tick", tick8, 0);
    chk("rst_count", cnt8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_sel", sa8, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      vtaps = tv[i].taps;
      sel8  = tv[i].sel;
      clr8  = tv[i].clr;
      step();
      chk($sformatf("v%0d_clk_out", i), co8, tv[i].co);
      chk($sformatf("v%0d_tick", i), tick8, tv[i].tk);
      chk($sformatf("v%0d_busy", i), busy8, tv[i].by);
      chk($sformatf("v%0d_sel", i), sa8, tv[i].sa);
      chk($sformatf("v%0d_count", i), cnt8, tv[i].cnt);
    end

    // Divider-driven run on tap 0 from a fresh reset.
    sel8 = 3'd0; clr8 = 1'b0; use_div = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      step();
      chk($sformatf("div0_e%0d_clk_out", k), co8, (k % 2 == 0));
      chk($sformatf("div0_e%0d_tick", k), tick8, (k % 2 == 0));
    end
    chk("div0_count50", cnt8, 50);
    chk("div0_busy", busy8, 0);

    // Switch 0 -> 3 while tap 0 is high.
    sel8 = 3'd3;
    step();
    chk("sw3_busy_rise", busy8, 1);
    chk("sw3_hold_high", co8, 1);
    step();
    chk("sw3_drain_low", co8, 0);
    chk("sw3_busy_mid", busy8, 1);
    step();
    chk("sw3_busy_fall", busy8, 0);
    chk("sw3_sel", sa8, 3);
    measure("sw3_p1", 8, 8);
    measure("sw3_p2", 8, 8);

    // 3 -> 7, then 1 requested mid-switch.
    sel8 = 3'd7;
    wait_busy(1'b1, 4, "sw7_busy_rise");
    sel8 = 3'd1;
    wait_busy(1'b0, 600, "sw7_busy_fall");
    chk("sw7_sel", sa8, 7);
    step();
    chk("sw1_busy_again", busy8, 1);
    wait_busy(1'b0, 20, "sw1_busy_fall");
    chk("sw1_sel", sa8, 1);
    measure("sw1_p1", 2, 2);

    // Reset asserted while draining tap 5.
    sel8 = 3'd5;
    wait_busy(1'b1, 4, "sw5_busy_rise");
    wait_busy(1'b0, 600, "sw5_busy_fall");
    chk("sw5_sel", sa8, 5);
    begin
      int n = 0;
      while (co8 !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      chk("sw5_high_seen", co8, 1);
    end
    sel8 = 3'd2;
    step();
    chk("drain_busy", busy8, 1);
    chk("drain_clk_out", co8, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_clk_out", co8, 0);
    chk("arst_busy", busy8, 0);
    chk("arst_sel", sa8, 0);
    chk("arst_count", cnt8, 0);
    chk("arst_tick", tick8, 0);
    sel8 = 3'd0;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_sel", sa8, 0);
    chk("post_rst_busy", busy8, 0);

    // NTAPS=2 build: out-of-range select and 4-bit wrap.
    chk("n2_start_count", cnt2, 0);
    for (int p = 0; p < 14; p++) pulse2(1'b0);
    chk("n2_count_e", cnt2, 4'hE);
    chk("n2_busy_ign", busy2, 0);
    pulse2(1'b0);
    chk("n2_count_f", cnt2, 4'hF);
    pulse2(1'b0);
    chk("n2_count_wrap", cnt2, 4'h0);
    pulse2(1'b0);
    chk("n2_count_1", cnt2, 4'h1);
    pulse2(1'b1);
    chk("n2_clr_tick", cnt2, 4'h0);
    chk("n2_busy_after", busy2, 0);
    chk("n2_sel_after", sa2, 0);
    sel2 = 3'd1;
    step();
    chk("n2_valid_busy", busy2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
